burst_arbiter_ctrl: RTL
=======================

Name: burst_arbiter_ctrl

Overview:
- Burst-level scheduler that shares the single processing datapath between slave port 0 and slave port 1.
- Grants one port at a time for a whole burst. The burst length is the port's proc_valid value.
- Throttles the granted port from the FIFO threshold and full flags, then waits for proc_cmplt before signalling completion to the master side.
- Sits between the two slave ports and the processing/FIFO path.

Parameters:
- DW, 32, data width of the slave and processing data buses.
- BURST_W, 8, width of proc_valid and of the beat counter.
- TIMEOUT, 64, idle-beat limit. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-high reset. Despite the name, 1 = reset, sampled on the clk rising edge.
- slv0_mode / slv1_mode  in  2  processing mode of each port.
- slv0_data_valid / slv1_data_valid  in  1  beat valid from each port.
- slv0_proc_valid / slv1_proc_valid  in  BURST_W  burst length in beats; 0 means no request.
- slv0_data / slv1_data  in  DW  beat data from each port.
- fifo_full, fifo_threshold  in  1  FIFO back-pressure flags.
- proc_cmplt  in  1  one-cycle pulse from processing when the last beat has been written.
- slv0_ready / slv1_ready  out  1  beat accept for each port.
- slvx_mode  out  2  mode latched at grant.
- slvx_data_valid  out  1  beat accepted this cycle.
- slvx_proc_val  out  BURST_W  burst length latched at grant.
- slvx_data  out  DW  data of the granted port.
- data_source  out  1  id of the granted port (0 or 1).
- mstr0_cmplt  out  1  one-cycle pulse when a burst is fully done.

Behaviour:
- Request rule: reqN = slvN_data_valid && (slvN_proc_valid != 0).
- FSM states: IDLE, BURST, DRAIN, DONE.
- IDLE:
  - Any request: pick a winner with the round-robin pointer (the port not granted last wins a tie).
  - Latch the winner's mode and proc_valid into slvx_mode/slvx_proc_val, and latch the beat counter = proc_valid.
  - Set data_source = winner and go to BURST. Ready therefore rises one cycle after the request is seen.
- BURST:
  - slvN_ready = (grant==N) && !fifo_threshold && !fifo_full. This is combinational; the ungranted port's ready is always 0.
  - beat = granted valid && ready; slvx_data_valid = beat.
  - slvx_data muxes the granted port's data every cycle.
  - Each beat decrements the counter.
  - Beat with counter==1: if proc_cmplt is also high that cycle, go to DONE; otherwise go to DRAIN.
  - Valid with no ready (back-pressure) is not a beat; the counter holds.
- DRAIN:
  - Both readies are 0.
  - Wait for proc_cmplt, then go to DONE. No time limit applies.
- DONE:
  - mstr0_cmplt = 1 for exactly one cycle.
  - Round-robin pointer <= data_source.
  - Go to IDLE. There is a minimum of one IDLE cycle between bursts.
- proc_cmplt in IDLE, or in BURST before the last beat, is ignored.
- The port's proc_valid and mode may change mid-burst; only the latched values are used.
- Reset values: state=IDLE, pointer=1 (port 0 wins the first tie), counter=0, data_source=0, slvx_mode=0, slvx_proc_val=0, slvx_data_valid=0, readies=0, mstr0_cmplt=0. slvx_data is a don't-care during reset.
- Reset asserted mid-burst: the burst is abandoned immediately and mstr0_cmplt is not issued.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A timer counts consecutive BURST cycles with no beat, including cycles blocked by fifo_threshold or fifo_full.
  - When it reaches TIMEOUT, the burst aborts: go to DRAIN if at least one beat was taken, otherwise go directly to DONE.
  - The abort also asserts mstr0_cmplt, and a sticky output timeout_err (1 bit) is set. timeout_err clears only on reset.
- When undefined: no timer, no timeout_err port; a burst waits indefinitely.

Decomposition:
- Package ip_pkg contains:
  - arb_state_e (IDLE, BURST, DRAIN, DONE);
  - mode_e (2-bit processing mode);
  - constants DW_DEF=32 and BURST_W_DEF=8.
- Sub-module rr_pick2: combinational 2-requester round-robin select. Inputs req[1:0] and last; outputs gnt_id and gnt_any.

Test Plan:
- Port 0 only: proc_valid=4, valid held 1 → ready rises 1 cycle later, 4 beats on consecutive cycles, DRAIN; proc_cmplt pulse → mstr0_cmplt 1 cycle later, data_source=0.
- Both ports request at the same cycle after reset → port 0 granted first. After its DONE, port 1 is granted while port 0 still requests, so the grants alternate 0,1,0.
- fifo_threshold high for 3 cycles mid-burst (proc_valid=6) → readies 0, counter holds, exactly 6 beats total, no lost or duplicated data.
- proc_cmplt coincident with the last beat → straight to DONE, mstr0_cmplt next cycle, no DRAIN cycle.
- Reset asserted in BURST after 2 of 5 beats → next cycle: state IDLE, all outputs 0, no mstr0_cmplt.
- With ARB_TIMEOUT_EN and TIMEOUT=8: grant taken, valid dropped after 1 beat → after 8 beat-less cycles, go to DRAIN, timeout_err=1, mstr0_cmplt pulses after proc_cmplt.

Source files
------------

// File: rtl/burst_arbiter_ctrl_pkg.sv
// Shared types and default sizes for the burst arbiter.
package ip_pkg;

    localparam int DW_DEF      = 32;
    localparam int BURST_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        MODE_0 = 2'd0,
        MODE_1 = 2'd1,
        MODE_2 = 2'd2,
        MODE_3 = 2'd3
    } mode_e;

endpackage

// File: rtl/burst_arbiter_ctrl_rr_pick2.sv
// Two-requester round-robin select: on a tie the port that was not granted last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_id,
    output logic       gnt_any
);

    always_comb begin
        gnt_any = |req;
        gnt_id  = 1'b0;
        if (req == 2'b11) begin
            gnt_id = ~last;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/burst_arbiter_ctrl.sv
// Burst-level scheduler sharing one processing datapath between two slave ports.
// Optional idle-beat timeout enabled by ARB_TIMEOUT_EN; dbg_state mirrors arb_state_e.
module burst_arbiter_ctrl
    import ip_pkg::*;
#(
    parameter int DW      = DW_DEF,
`ifdef ARB_TIMEOUT_EN
    parameter int TIMEOUT = 64,
`endif
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         slv0_mode,
    input  logic [1:0]         slv1_mode,
    input  logic               slv0_data_valid,
    input  logic               slv1_data_valid,
    input  logic [BURST_W-1:0] slv0_proc_valid,
    input  logic [BURST_W-1:0] slv1_proc_valid,
    input  logic [DW-1:0]      slv0_data,
    input  logic [DW-1:0]      slv1_data,
    input  logic               fifo_full,
    input  logic               fifo_threshold,
    input  logic               proc_cmplt,
    output logic               slv0_ready,
    output logic               slv1_ready,
    output logic [1:0]         slvx_mode,
    output logic               slvx_data_valid,
    output logic [BURST_W-1:0] slvx_proc_val,
    output logic [DW-1:0]      slvx_data,
    output logic               data_source,
    output logic               mstr0_cmplt,
`ifdef ARB_TIMEOUT_EN
    output logic               timeout_err,
`endif
    output logic [1:0]         dbg_state
);

    arb_state_e         state;
    arb_state_e         state_nxt;
    mode_e              mode_q;
    logic [BURST_W-1:0] proc_val_q;
    logic [BURST_W-1:0] cnt;
    logic               src;
    logic               last_gnt;
    logic [1:0]         req;
    logic               pick_id;
    logic               pick_any;
    logic               gnt_valid;
    logic               beat;
    logic               abort;

    assign req = {slv1_data_valid && (slv1_proc_valid != '0),
                  slv0_data_valid && (slv0_proc_valid != '0)};

    rr_pick2 u_pick (
        .req     (req),
        .last    (last_gnt),
        .gnt_id  (pick_id),
        .gnt_any (pick_any)
    );

    // A beat moves on a cycle where the granted port has valid high and its ready is high;
    // valid without ready is a stall and the beat counter holds.
    always_comb begin
        slv0_ready = 1'b0;
        slv1_ready = 1'b0;
        if (state == BURST && !fifo_threshold && !fifo_full) begin
            slv0_ready = !src;
            slv1_ready = src;
        end
    end

    assign gnt_valid       = src ? slv1_data_valid : slv0_data_valid;
    assign beat            = gnt_valid && (slv0_ready || slv1_ready);
    assign slvx_data_valid = beat;
    assign slvx_data       = src ? slv1_data : slv0_data;
    assign data_source     = src;
    assign slvx_mode       = mode_q;
    assign slvx_proc_val   = proc_val_q;
    assign mstr0_cmplt     = (state == DONE);
    assign dbg_state       = state;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] stall_cnt;

    // Fires on the TIMEOUT-th consecutive beat-less cycle of a burst.
    assign abort = (state == BURST) && !beat && (stall_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != BURST || beat) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + TW'(1);
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (beat && cnt == BURST_W'(1)) begin
                    state_nxt = proc_cmplt ? DONE : DRAIN;
                end else if (abort) begin
                    // Beats already handed downstream must still be retired by proc_cmplt.
                    state_nxt = (cnt != proc_val_q) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (proc_cmplt) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            cnt        <= '0;
            src        <= 1'b0;
            mode_q     <= MODE_0;
            proc_val_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_any) begin
                src        <= pick_id;
                mode_q     <= mode_e'(pick_id ? slv1_mode : slv0_mode);
                proc_val_q <= pick_id ? slv1_proc_valid : slv0_proc_valid;
                cnt        <= pick_id ? slv1_proc_valid : slv0_proc_valid;
            end else if (beat) begin
                cnt <= cnt - BURST_W'(1);
            end
            if (state == DONE) begin
                last_gnt <= src;
            end
        end
    end

endmodule
